// File: rtl/run_ctrl_if.sv
// Control bundle between the run sequencer and the host/decode side.
// The host drives requests in; the sequencer drives fetch-unit strobes and run status out.
interface run_ctrl_if;
    logic        start;
    logic        abort;
    logic [1:0]  prog_sel;
    logic        halt_in;
    logic        step_en;
    logic        step;
    logic        core_init;
    logic        core_req;
    logic        core_halt;
    logic        ack;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [1:0]  cur_prog;
    logic [15:0] run_cycles;

    modport master (
        output start, abort, prog_sel, halt_in, step_en, step,
        input  core_init, core_req, core_halt, ack, busy, done, timeout, cur_prog, run_cycles
    );

    modport slave (
        input  start, abort, prog_sel, halt_in, step_en, step,
        output core_init, core_req, core_halt, ack, busy, done, timeout, cur_prog, run_cycles
    );
endinterface

// File: rtl/run_ctrl.sv
// Program-run sequencer: launches the fetch unit, counts run cycles, supports
// single-step, and ends a run on a halt instruction, a cycle budget, or abort.
module run_ctrl #(
    parameter logic [15:0] MAX_CYCLES = 16'd4096
) (
    input logic       clk,
    input logic       Init_n,
    run_ctrl_if.slave bus
);

    typedef enum logic [2:0] {IDLE, INIT, LAUNCH, RUN, STEP, DONE} state_t;

    state_t      state_reg, state_next;
    logic        step_en_reg, step_prev_reg;
    logic        timeout_reg, timeout_next;
    logic [1:0]  cur_prog_reg, cur_prog_next;
    logic [15:0] run_cycles_reg, run_cycles_next;

    logic        step_edge, budget_hit, accept, running;
    logic        core_init_dec, core_req_dec, core_halt_dec, ack_dec, busy_dec, done_dec;

    assign step_edge  = bus.step & ~step_prev_reg;
    assign budget_hit = (run_cycles_reg == MAX_CYCLES);
    assign running    = (state_reg == RUN) || (state_reg == STEP);
    assign accept     = ((state_reg == IDLE) || (state_reg == DONE)) && bus.start && !bus.abort;

    always_ff @(posedge clk or negedge Init_n) begin
        if (!Init_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (bus.abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE, DONE: if (bus.start) state_next = INIT;
                INIT:       state_next = LAUNCH;
                LAUNCH:     state_next = RUN;
                RUN: begin
                    if (bus.halt_in || budget_hit)      state_next = DONE;
                    else if (step_en_reg && step_edge)  state_next = STEP;
                end
                STEP: begin
                    if (bus.halt_in || budget_hit) state_next = DONE;
                    else                           state_next = RUN;
                end
                default:    state_next = IDLE;
            endcase
        end
    end

    // Strobes come only from registered state; in RUN the core is also held once
    // the budget is used up so the timeout cycle itself gives it no extra work.
    always_comb begin
        core_init_dec = 1'b0;
        core_req_dec  = 1'b0;
        core_halt_dec = 1'b1;
        ack_dec       = 1'b0;
        busy_dec      = 1'b0;
        done_dec      = 1'b0;
        case (state_reg)
            INIT: begin
                core_init_dec = 1'b1;
                ack_dec       = 1'b1;
                busy_dec      = 1'b1;
            end
            LAUNCH: begin
                core_req_dec  = 1'b1;
                core_halt_dec = 1'b0;
                busy_dec      = 1'b1;
            end
            RUN: begin
                core_halt_dec = step_en_reg | budget_hit;
                busy_dec      = 1'b1;
            end
            STEP: begin
                core_halt_dec = 1'b0;
                busy_dec      = 1'b1;
            end
            DONE:    done_dec = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        cur_prog_next   = accept ? bus.prog_sel : cur_prog_reg;
        run_cycles_next = run_cycles_reg;
        if (accept) begin
            run_cycles_next = 16'h0000;
        end else if (!core_halt_dec && (run_cycles_reg != 16'hFFFF)) begin
            run_cycles_next = run_cycles_reg + 16'd1;
        end
        timeout_next = timeout_reg;
        if (bus.abort || accept) begin
            timeout_next = 1'b0;
        end else if (running && !bus.halt_in && budget_hit) begin
            timeout_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge Init_n) begin
        if (!Init_n) begin
            step_en_reg    <= 1'b0;
            step_prev_reg  <= 1'b0;
            timeout_reg    <= 1'b0;
            cur_prog_reg   <= 2'b00;
            run_cycles_reg <= 16'h0000;
        end else begin
            step_en_reg    <= bus.step_en;
            step_prev_reg  <= bus.step;
            timeout_reg    <= timeout_next;
            cur_prog_reg   <= cur_prog_next;
            run_cycles_reg <= run_cycles_next;
        end
    end

    assign bus.core_init  = core_init_dec;
    assign bus.core_req   = core_req_dec;
    assign bus.core_halt  = core_halt_dec;
    assign bus.ack        = ack_dec;
    assign bus.busy       = busy_dec;
    assign bus.done       = done_dec;
    assign bus.timeout    = timeout_reg;
    assign bus.cur_prog   = cur_prog_reg;
    assign bus.run_cycles = run_cycles_reg;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: two instances (default budget and an 8-cycle budget) share
// stimulus; a monitor pops expected ack/done records from per-instance queues.
module tb_run_ctrl;

    typedef struct packed {
        logic        timeout;
        logic [15:0] cycles;
        logic [1:0]  prog;
    } exp_t;

    logic clk = 1'b0;
    logic Init_n = 1'b0;
    logic start = 1'b0, abort = 1'b0, halt_in = 1'b0, step_en = 1'b0, step = 1'b0;
    logic [1:0] prog_sel = 2'b00;

    int   checks = 0;
    int   errors = 0;
    int   low_cnt = 0;
    logic count_low = 1'b0;

    exp_t       q_big[$];
    exp_t       q_small[$];
    logic [1:0] q_ack_big[$];
    logic [1:0] q_ack_small[$];

    localparam logic [31:0] RST_VAL = 32'({7'b0010000, 2'b00, 16'h0000});

    always #5 clk = ~clk;

    run_ctrl_if if_big ();
    run_ctrl_if if_small ();

    assign if_big.start   = start;   assign if_small.start   = start;
    assign if_big.abort   = abort;   assign if_small.abort   = abort;
    assign if_big.prog_sel = prog_sel; assign if_small.prog_sel = prog_sel;
    assign if_big.halt_in = halt_in; assign if_small.halt_in = halt_in;
    assign if_big.step_en = step_en; assign if_small.step_en = step_en;
    assign if_big.step    = step;    assign if_small.step    = step;

    run_ctrl dut_big (
        .clk    (clk),
        .Init_n (Init_n),
        .bus    (if_big)
    );

    run_ctrl #(.MAX_CYCLES(16'd8)) dut_small (
        .clk    (clk),
        .Init_n (Init_n),
        .bus    (if_small)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_big();
        return 32'({if_big.core_init, if_big.core_req, if_big.core_halt, if_big.ack,
                    if_big.busy, if_big.done, if_big.timeout, if_big.cur_prog, if_big.run_cycles});
    endfunction

    function automatic logic [31:0] pack_small();
        return 32'({if_small.core_init, if_small.core_req, if_small.core_halt, if_small.ack,
                    if_small.busy, if_small.done, if_small.timeout, if_small.cur_prog, if_small.run_cycles});
    endfunction

    task automatic monitor();
        logic       pd_big = 1'b0;
        logic       pd_small = 1'b0;
        exp_t       e;
        logic [1:0] p;
        forever begin
            @(negedge clk);
            if (count_low && !if_big.core_halt) low_cnt++;
            if (if_big.ack) begin
                if (q_ack_big.size() == 0) check("ack_big_unexpected", 32'(if_big.ack), 32'd0);
                else begin
                    p = q_ack_big.pop_front();
                    check("ack_prog_big", 32'(if_big.cur_prog), 32'(p));
                    check("ack_strobes_big", 32'({if_big.core_init, if_big.core_halt, if_big.busy}), 32'd7);
                end
            end
            if (if_small.ack) begin
                if (q_ack_small.size() == 0) check("ack_small_unexpected", 32'(if_small.ack), 32'd0);
                else begin
                    p = q_ack_small.pop_front();
                    check("ack_prog_small", 32'(if_small.cur_prog), 32'(p));
                end
            end
            if (if_big.done && !pd_big) begin
                if (q_big.size() == 0) check("done_big_unexpected", 32'(if_big.done), 32'd0);
                else begin
                    e = q_big.pop_front();
                    check("done_big", 32'({if_big.timeout, if_big.run_cycles, if_big.cur_prog}), 32'(e));
                end
            end
            if (if_small.done && !pd_small) begin
                if (q_small.size() == 0) check("done_small_unexpected", 32'(if_small.done), 32'd0);
                else begin
                    e = q_small.pop_front();
                    check("done_small", 32'({if_small.timeout, if_small.run_cycles, if_small.cur_prog}), 32'(e));
                end
            end
            pd_big   = if_big.done;
            pd_small = if_small.done;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic start_run(input logic [1:0] p);
        prog_sel = p;
        start = 1'b1;
        q_ack_big.push_back(p);
        q_ack_small.push_back(p);
        tick();
        start = 1'b0;
        check("init_clears", 32'({if_big.done, if_big.timeout, if_big.run_cycles}), 32'd0);
    endtask

    // Halt instruction seen during the n-th run cycle (LAUNCH is run cycle 1).
    task automatic run_halt(input logic [1:0] p, input int n);
        exp_t es;
        q_big.push_back('{timeout: 1'b0, cycles: 16'(n), prog: p});
        if (n <= 8)      es = '{timeout: 1'b0, cycles: 16'(n), prog: p};
        else if (n == 9) es = '{timeout: 1'b0, cycles: 16'd8, prog: p};
        else             es = '{timeout: 1'b1, cycles: 16'd8, prog: p};
        q_small.push_back(es);
        start_run(p);
        check("init_cycle", 32'({if_big.ack, if_big.core_init, if_big.busy, if_big.core_halt, if_big.cur_prog}),
              32'({4'b1111, p}));
        tick();
        check("launch_cycle", 32'({if_big.core_req, if_big.core_halt, if_big.ack, if_big.busy}), 32'b1001);
        ticks(n - 1);
        halt_in = 1'b1;
        tick();
        halt_in = 1'b0;
        ticks(2);
        check("done_hold", 32'({if_big.done, if_big.core_halt, if_big.busy}), 32'b110);
    endtask

    initial begin
        fork
            monitor();
        join_none

        #2;
        check("reset_big", pack_big(), RST_VAL);
        check("reset_small", pack_small(), RST_VAL);
        repeat (2) @(posedge clk);
        #1 Init_n = 1'b1;
        tick();
        check("idle_after_release", pack_big(), RST_VAL);

        run_halt(2'd2, 10);
        run_halt(2'd1, 8);
        run_halt(2'd3, 9);

        // No halt: small instance times out, big one is aborted; start mid-run is ignored.
        q_small.push_back('{timeout: 1'b1, cycles: 16'd8, prog: 2'd1});
        start_run(2'd1);
        ticks(3);
        prog_sel = 2'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy_ignored", 32'({if_big.busy, if_big.cur_prog}), 32'({1'b1, 2'd1}));
        ticks(8);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_big", 32'({if_big.busy, if_big.core_halt, if_big.done, if_big.timeout, if_big.cur_prog, if_big.run_cycles}),
              32'({4'b0100, 2'd1, 16'd12}));
        check("abort_small", 32'({if_small.busy, if_small.done, if_small.timeout, if_small.run_cycles}),
              32'({3'b000, 16'd8}));

        // start and abort together from IDLE: nothing happens.
        prog_sel = 2'd3;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", 32'({if_big.busy, if_big.ack, if_big.cur_prog}), 32'({2'b00, 2'd1}));
        tick();
        check("start_abort_idle2", 32'({if_big.busy, if_small.busy}), 32'd0);

        // Single-step: a step edge in IDLE is discarded, then three steps in RUN.
        step_en = 1'b1;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        q_big.push_back('{timeout: 1'b0, cycles: 16'd4, prog: 2'd0});
        q_small.push_back('{timeout: 1'b0, cycles: 16'd4, prog: 2'd0});
        low_cnt = 0;
        count_low = 1'b1;
        start_run(2'd0);
        ticks(2);
        check("step_hold", 32'({if_big.busy, if_big.core_halt}), 32'b11);
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            ticks(2);
        end
        halt_in = 1'b1;
        tick();
        halt_in = 1'b0;
        ticks(2);
        count_low = 1'b0;
        step_en = 1'b0;
        check("step_run_cycles", 32'(low_cnt), 32'd4);

        // Reset asserted between clock edges during a run.
        start_run(2'd2);
        ticks(4);
        #2 Init_n = 1'b0;
        #1;
        check("async_reset_big", pack_big(), RST_VAL);
        check("async_reset_small", pack_small(), RST_VAL);
        ticks(2);
        Init_n = 1'b1;
        tick();
        check("post_reset_idle", pack_big(), RST_VAL);

        run_halt(2'd3, 5);

        ticks(3);
        check("pending_big", 32'(q_big.size()), 32'd0);
        check("pending_small", 32'(q_small.size()), 32'd0);
        check("pending_ack", 32'(q_ack_big.size() + q_ack_small.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter MAX_CYCLES, default 16'd4096, run-cycle budget before forced timeout.
REQ-002 clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 Init_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to launch a program run; sampled each posedge.
REQ-005 abort  input  1  force return to IDLE from any state.
REQ-006 prog_sel  input  2  program number, latched on start acceptance.
REQ-007 halt_in  input  1  from decode: halt instruction executing this cycle.
REQ-008 step_en  input  1  single-step mode when 1.
REQ-009 step  input  1  step request; one core cycle per 0->1 transition.
REQ-010 core_init  output  1  drives the fetch unit's Init.
REQ-011 core_req  output  1  drives the fetch unit's req (releases it from halted).
REQ-012 core_halt  output  1  drives the fetch unit's Halt.
REQ-013 ack  output  1  start accepted; one-cycle pulse.
REQ-014 busy  output  1  run in progress (INIT, LAUNCH, RUN, STEP).
REQ-015 done  output  1  run finished; held until next accepted start, abort or reset.
REQ-016 timeout  output  1  run ended by budget exhaustion; valid while done=1.
REQ-017 cur_prog  output  2  latched prog_sel of current/last run.
REQ-018 run_cycles  output  16  count of cycles the core ran (core_halt=0).

Function
REQ-019 FSM states IDLE, INIT, LAUNCH, RUN, STEP, DONE; core_init, core_req, core_halt, ack, busy are decoded from the state register only (Moore).
REQ-020 IDLE: core_halt=1, other strobes 0; start=1 and abort=0 -> INIT.
REQ-021 DONE: core_halt=1, done=1; start=1 and abort=0 -> INIT; otherwise stay.
REQ-022 Start acceptance (IDLE/DONE -> INIT): latch cur_prog<=prog_sel, clear run_cycles, done, timeout.
REQ-023 start while busy is ignored; no ack, no state change.
REQ-024 INIT: exactly one cycle; core_init=1, ack=1, core_halt=1; -> LAUNCH.
REQ-025 LAUNCH: exactly one cycle; core_req=1, core_halt=0; counts as a run cycle; -> RUN.
REQ-026 RUN with step_en=0: core_halt=0 every cycle.
REQ-027 RUN with step_en=1: core_halt=1; step 0->1 edge (registered previous step) -> STEP.
REQ-028 STEP: exactly one cycle, core_halt=0; -> RUN.
REQ-029 run_cycles increments by 1 each cycle with core_halt=0 in LAUNCH/RUN/STEP; 16-bit, saturates at 16'hFFFF, no wrap.
REQ-030 In RUN/STEP, halt_in=1 -> DONE with timeout=0.
REQ-031 In RUN/STEP, halt_in=0 and run_cycles==MAX_CYCLES -> DONE with timeout=1; core receives no further run cycles.
REQ-032 halt_in and budget reached in same cycle: halt_in wins, timeout=0.
REQ-033 halt_in outside RUN/STEP is ignored.
REQ-034 abort=1 in any state -> IDLE next cycle; clears done and timeout; run_cycles and cur_prog hold; abort beats start.
REQ-035 step_en changes take effect next RUN cycle; step edges outside RUN are discarded.

Reset
REQ-036 Init_n=0 asynchronously forces IDLE, core_halt=1, core_init=0, core_req=0, ack=0, busy=0, done=0, timeout=0, cur_prog=0, run_cycles=0, step edge register=0.
REQ-037 Reset mid-run takes effect immediately, no completion of INIT/LAUNCH pulses; first post-release state is IDLE.

Verification
REQ-038 Reset release, start=1 for 1 cycle with prog_sel=2 -> ack and core_init high cycle 1, core_req cycle 2, busy=1, cur_prog=2.
REQ-039 Run, halt_in=1 after 10 run cycles -> done=1, timeout=0, run_cycles=10, core_halt=1 held.
REQ-040 MAX_CYCLES=8, halt_in never -> done=1, timeout=1, run_cycles=8; halt_in on cycle 8 -> timeout=0.
REQ-041 step_en=1, three step pulses -> exactly three single cycles core_halt=0 after LAUNCH; run_cycles=4.
REQ-042 Start during RUN ignored; abort during RUN -> IDLE next cycle, busy=0, core_halt=1; start+abort together in IDLE -> stays IDLE.
REQ-043 Init_n low during RUN -> all outputs at reset values same cycle, no clock edge required.
